lif_block_n: RTL and testbench
==============================

Name: lif_block_n

Overview:
Parametrised next-generation neuron tile for the async-proc fabric.
- Accepts N_IN packed input channels, registers them on a step strobe, and applies per-channel signed weights.
- Integrates the weighted sum into a leaky, saturating membrane potential. Emits a single-cycle spike on threshold crossing, then holds for a programmable refractory period.
- Weights, threshold and refractory length are runtime-configurable over a small write port. Tiles chain through out/spike.

Parameters:
N_IN, 4, number of input channels
IN_W, 4, unsigned width of each input channel
WGT_W, 4, signed weight width per channel
POT_W, 8, unsigned membrane potential width
OUT_W, 4, width of out (upper bits of potential)
REF_W, 3, refractory counter width
LEAK_SHIFT, 2, leak = pot >> LEAK_SHIFT per step

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
step  in  1  step strobe; samples in_flat
in_flat  in  N_IN*IN_W  channel i at bits [i*IN_W +: IN_W]
cfg_we  in  1  config write enable
cfg_addr  in  clog2(N_IN+2)  0..N_IN-1 weight i; N_IN threshold; N_IN+1 refractory length
cfg_data  in  max(WGT_W,POT_W,REF_W)  write data, low bits used
out  out  OUT_W  pot[POT_W-1 -: OUT_W]
spike  out  1  one-cycle fire pulse
refractory  out  1  high while in REFRACT

Behaviour:
- Reset (rst_n=0 at posedge): pot=0, spike=0, state=INTEGRATE, ref_cnt=0, input buffer=0, stage valid=0. Weights=+1, threshold=2^(POT_W-1), ref_len=2. Outputs read 0 the cycle after reset. Reset mid-operation discards any in-flight step.
- Pipeline: step=1 at edge t captures in_flat into buf and sets v1=1. At edge t+1, when v1=1, the core updates pot/state/spike. Latency: step to spike is 2 edges. Back-to-back steps are allowed, one update per cycle.
- Weighted sum: S = sum(buf_i * w_i), signed, width IN_W+WGT_W+clog2(N_IN)+1, no overflow.
- INTEGRATE update: n = pot - (pot >> LEAK_SHIFT) + S, computed signed and clamped to [0, 2^POT_W-1].
  - If n >= threshold: spike=1, pot=0. Then go to REFRACT with ref_cnt=ref_len if ref_len!=0; otherwise stay in INTEGRATE.
  - Else pot=n.
- REFRACT update: inputs are ignored, pot stays 0, and ref_cnt decrements. When ref_cnt reaches 0 (i.e. after ref_len updates), return to INTEGRATE. The step that ends refractory does not integrate.
- spike is high exactly one cycle per fire. It is low on all cycles without an update.
- threshold=0: every INTEGRATE update fires.
- Config write: takes effect at the write edge. If the write lands on the same edge as an update, the update uses the old value. Writing ref_len during REFRACT does not alter the running ref_cnt. Writes to addresses > N_IN+1 are ignored.
- No update when v1=0: pot is held and there is no leak.

Decomposition:
- Package lif_pkg holds:
  - the state enum {INTEGRATE, REFRACT};
  - cfg address offset constants (ADDR_THRESH = N_IN, ADDR_REF = N_IN+1);
  - reset defaults (weight +1, ref_len 2).
- Sub-module lif_core contains the weighted sum, leak, clamp, compare, state machine and ref counter. lif_block_n holds the input buffer, v1, config registers and out slicing.

Test Plan:
- Defaults, LEAK_SHIFT=2, threshold=128, all inputs 15, continuous step → pot 60, 105, then spike on the 3rd update with pot=0. refractory is high for the next 2 updates and no spike occurs even with inputs 15. The 1st post-refractory update gives pot 60.
- Inhibition: w0=-8, others +1, in0=15, others 0 → S=-120, pot clamps at 0 and out=0. With pot=100 beforehand → 0.
- Saturation: all weights 7, inputs 15, threshold=255 → first update n clamps to 255, spike=1, pot=0.
- ref_len=0 and threshold=1, inputs 1 → spike on every step, refractory never high.
- Same-edge cfg write of threshold 10 while pot would become 60 against old threshold 128 → no spike. The next step (pot 105 ≥ 10) spikes.
- Reset asserted one cycle after step → no spike, pot=0, v1 cleared, and config is back to defaults.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, configuration address map and reset defaults for the LIF neuron tile.
package lif_pkg;

   typedef enum logic {
      INTEGRATE = 1'b0,
      REFRACT   = 1'b1
   } lif_state_e;

   // Reset values: unit excitatory weights and a two-update refractory window.
   localparam int WGT_RST     = 1;
   localparam int REF_LEN_RST = 2;

   // Config address map: weights occupy 0..n_in-1, then threshold, then ref_len.
   function automatic int addr_thresh(input int n_in);
      return n_in;
   endfunction

   function automatic int addr_ref(input int n_in);
      return n_in + 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lif_core.sv
// Neuron core: weighted sum, leak, clamp, threshold compare and refractory state machine.
module lif_core
   import lif_pkg::*;
#(
   parameter int N_IN       = 4,
   parameter int IN_W       = 4,
   parameter int WGT_W      = 4,
   parameter int POT_W      = 8,
   parameter int REF_W      = 3,
   parameter int LEAK_SHIFT = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    upd,
   input  logic [N_IN*IN_W-1:0]    in_buf,
   input  logic [N_IN*WGT_W-1:0]   wgt_flat,
   input  logic [POT_W-1:0]        thresh,
   input  logic [REF_W-1:0]        ref_len,
   output logic [POT_W-1:0]        pot,
   output logic                    spike,
   output logic                    refractory
);

   localparam int SUM_W = IN_W + WGT_W + $clog2(N_IN) + 1;
   localparam int NXT_W = ((SUM_W > POT_W + 1) ? SUM_W : POT_W + 1) + 1;
   localparam logic signed [NXT_W-1:0] POT_MAX = NXT_W'((2 ** POT_W) - 1);

   lif_state_e              state, state_nxt;
   logic [REF_W-1:0]        ref_cnt, cnt_nxt;
   logic [POT_W-1:0]        pot_nxt;
   logic                    spike_nxt;
   logic signed [SUM_W-1:0] prod [N_IN];
   logic signed [SUM_W-1:0] sum;
   logic [POT_W-1:0]        leaked;
   logic signed [NXT_W-1:0] n_raw;
   logic [POT_W-1:0]        n_clamp;

   // Inputs are unsigned, so a zero is prepended before treating them as signed.
   for (genvar i = 0; i < N_IN; i++) begin : g_prod
      assign prod[i] = SUM_W'(signed'({1'b0, in_buf[i*IN_W +: IN_W]}))
                     * SUM_W'(signed'(wgt_flat[i*WGT_W +: WGT_W]));
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < N_IN; i++) begin
         sum = sum + prod[i];
      end
   end

   assign leaked = pot - (pot >> LEAK_SHIFT);
   assign n_raw  = NXT_W'(signed'({1'b0, leaked})) + NXT_W'(sum);

   always_comb begin
      if (n_raw < 0) begin
         n_clamp = '0;
      end else if (n_raw > POT_MAX) begin
         n_clamp = '1;
      end else begin
         n_clamp = n_raw[POT_W-1:0];
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt = state;
      pot_nxt   = pot;
      cnt_nxt   = ref_cnt;
      spike_nxt = 1'b0;
      if (upd) begin
         case (state)
            INTEGRATE: begin
               if (n_clamp >= thresh) begin
                  spike_nxt = 1'b1;
                  pot_nxt   = '0;
                  if (ref_len != '0) begin
                     state_nxt = REFRACT;
                     cnt_nxt   = ref_len;
                  end
               end else begin
                  pot_nxt = n_clamp;
               end
            end
            REFRACT: begin
               pot_nxt = '0;
               cnt_nxt = ref_cnt - REF_W'(1);
               if (ref_cnt == REF_W'(1)) begin
                  state_nxt = INTEGRATE;
               end
            end
            default: state_nxt = INTEGRATE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state   <= INTEGRATE;
         pot     <= '0;
         ref_cnt <= '0;
         spike   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pot     <= pot_nxt;
         ref_cnt <= cnt_nxt;
         spike   <= spike_nxt;
      end
   end

   assign refractory = (state == REFRACT);

endmodule

// File: rtl/lif_block_n.sv
// LIF neuron tile: step-strobed input buffer, runtime config registers and the neuron core.
module lif_block_n
   import lif_pkg::*;
#(
   parameter int N_IN       = 4,
   parameter int IN_W       = 4,
   parameter int WGT_W      = 4,
   parameter int POT_W      = 8,
   parameter int OUT_W      = 4,
   parameter int REF_W      = 3,
   parameter int LEAK_SHIFT = 2,
   localparam int ADDR_W    = $clog2(N_IN + 2),
   localparam int DATA_W    = max3(WGT_W, POT_W, REF_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  step,
   input  logic [N_IN*IN_W-1:0]  in_flat,
   input  logic                  cfg_we,
   input  logic [ADDR_W-1:0]     cfg_addr,
   input  logic [DATA_W-1:0]     cfg_data,
   output logic [OUT_W-1:0]      out,
   output logic                  spike,
   output logic                  refractory
);

   logic [N_IN*IN_W-1:0]  in_buf;
   logic                  v1;
   logic [N_IN*WGT_W-1:0] wgt_flat;
   logic [POT_W-1:0]      thresh;
   logic [REF_W-1:0]      ref_len;
   logic [POT_W-1:0]      pot;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_buf   <= '0;
         v1       <= 1'b0;
         // NOTE: the weight table is reset on purpose; the tile must fire sensibly with no config.
         wgt_flat <= {N_IN{WGT_W'(WGT_RST)}};
         thresh   <= {1'b1, {(POT_W-1){1'b0}}};
         ref_len  <= REF_W'(REF_LEN_RST);
      end else begin
         v1 <= step;
         if (step) begin
            in_buf <= in_flat;
         end
         if (cfg_we) begin
            for (int i = 0; i < N_IN; i++) begin
               if (cfg_addr == ADDR_W'(i)) begin
                  wgt_flat[i*WGT_W +: WGT_W] <= cfg_data[WGT_W-1:0];
               end
            end
            if (cfg_addr == ADDR_W'(addr_thresh(N_IN))) begin
               thresh <= cfg_data[POT_W-1:0];
            end
            if (cfg_addr == ADDR_W'(addr_ref(N_IN))) begin
               ref_len <= cfg_data[REF_W-1:0];
            end
         end
      end
   end

   lif_core #(
      .N_IN       (N_IN),
      .IN_W       (IN_W),
      .WGT_W      (WGT_W),
      .POT_W      (POT_W),
      .REF_W      (REF_W),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd        (v1),
      .in_buf     (in_buf),
      .wgt_flat   (wgt_flat),
      .thresh     (thresh),
      .ref_len    (ref_len),
      .pot        (pot),
      .spike      (spike),
      .refractory (refractory)
   );

   assign out = pot[POT_W-1 -: OUT_W];

endmodule

// File: tb/tb_lif_block_n.sv
// Self-checking bench for lif_block_n: directed scenarios plus random traffic against an integer model.
module tb_lif_block_n;

   localparam int N_IN       = 4;
   localparam int IN_W       = 4;
   localparam int WGT_W      = 4;
   localparam int POT_W      = 8;
   localparam int OUT_W      = 4;
   localparam int REF_W      = 3;
   localparam int LEAK_SHIFT = 2;
   localparam int ADDR_W     = 3;
   localparam int DATA_W     = 8;
   localparam logic [15:0] ALL15 = 16'hFFFF;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 step;
   logic [N_IN*IN_W-1:0] in_flat;
   logic                 cfg_we;
   logic [ADDR_W-1:0]    cfg_addr;
   logic [DATA_W-1:0]    cfg_data;
   logic [OUT_W-1:0]     out;
   logic                 spike;
   logic                 refractory;

   always #5 clk = ~clk;

   lif_block_n #(
      .N_IN       (N_IN),
      .IN_W       (IN_W),
      .WGT_W      (WGT_W),
      .POT_W      (POT_W),
      .OUT_W      (OUT_W),
      .REF_W      (REF_W),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (step),
      .in_flat    (in_flat),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .out        (out),
      .spike      (spike),
      .refractory (refractory)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: plain integers, refractory tracked as "updates still to skip".
   int m_pot;
   int m_left;
   int m_thr;
   int m_ref;
   int m_w   [N_IN];
   int m_buf [N_IN];
   bit m_v;
   bit m_spike;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_edge(input bit rst, input bit stp, input logic [15:0] din,
                             input bit we, input int addr, input int data);
      int s;
      int n;
      int wv;
      if (!rst) begin
         m_pot = 0; m_left = 0; m_spike = 0; m_v = 0;
         m_thr = 128; m_ref = 2;
         for (int i = 0; i < N_IN; i++) begin
            m_w[i] = 1; m_buf[i] = 0;
         end
         return;
      end
      m_spike = 0;
      if (m_v) begin
         if (m_left > 0) begin
            m_left--;
            m_pot = 0;
         end else begin
            s = 0;
            for (int i = 0; i < N_IN; i++) s += m_buf[i] * m_w[i];
            n = m_pot - (m_pot >> LEAK_SHIFT) + s;
            if (n < 0) n = 0;
            if (n > 255) n = 255;
            if (n >= m_thr) begin
               m_spike = 1;
               m_pot = 0;
               m_left = m_ref;
            end else begin
               m_pot = n;
            end
         end
      end
      m_v = stp;
      if (stp) begin
         for (int i = 0; i < N_IN; i++) m_buf[i] = int'((din >> (i * IN_W)) & 16'hF);
      end
      if (we) begin
         if (addr < N_IN) begin
            wv = data & 15;
            if (wv >= 8) wv -= 16;
            m_w[addr] = wv;
         end else if (addr == N_IN) begin
            m_thr = data & 255;
         end else if (addr == N_IN + 1) begin
            m_ref = data & 7;
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit stp, input logic [15:0] din,
                        input bit we = 1'b0, input int addr = 0, input int data = 0,
                        input string tag = "cyc");
      rst_n    = rst;
      step     = stp;
      in_flat  = din;
      cfg_we   = we;
      cfg_addr = ADDR_W'(addr);
      cfg_data = DATA_W'(data);
      @(posedge clk);
      model_edge(rst, stp, din, we, addr, data);
      #1;
      check({tag, ".out"}, 32'(out), 32'(m_pot >> (POT_W - OUT_W)));
      check({tag, ".spike"}, 32'(spike), 32'(m_spike));
      check({tag, ".refr"}, 32'(refractory), 32'(m_left > 0));
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 0, 0, "rst");
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 0, 0, "rst");
   endtask

   initial begin
      // Reset state
      do_reset();
      check("reset.out", 32'(out), 0);
      check("reset.spike", 32'(spike), 0);
      check("reset.refr", 32'(refractory), 0);

      // Default config, continuous full-scale input: 60, 105, fire, 2 refractory updates, 60
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      check("t1.pot60", 32'(out), 3);
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      check("t1.pot105", 32'(out), 6);
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      check("t1.fire", 32'(spike), 1);
      check("t1.fire_pot", 32'(out), 0);
      check("t1.refr_on", 32'(refractory), 1);
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      check("t1.refr_hold", 32'(refractory), 1);
      check("t1.no_spike1", 32'(spike), 0);
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      check("t1.refr_end", 32'(refractory), 0);
      check("t1.no_spike2", 32'(spike), 0);
      check("t1.no_integ", 32'(out), 0);
      cycle(1, 1, ALL15, 0, 0, 0, "t1");
      check("t1.post_pot60", 32'(out), 3);

      // Inhibition from pot 105 clamps to zero
      do_reset();
      cycle(1, 1, ALL15, 0, 0, 0, "t2");
      cycle(1, 1, ALL15, 0, 0, 0, "t2");
      cycle(1, 0, ALL15, 1, 0, 8'hF8, "t2");
      check("t2.pot105", 32'(out), 6);
      cycle(1, 1, 16'h000F, 0, 0, 0, "t2");
      check("t2.hold_no_leak", 32'(out), 6);
      cycle(1, 0, 16'h0, 0, 0, 0, "t2");
      check("t2.clamp0", 32'(out), 0);
      check("t2.no_spike", 32'(spike), 0);

      // Saturation: weights 7, threshold 255
      do_reset();
      for (int i = 0; i < N_IN; i++) cycle(1, 0, 16'h0, 1, i, 7, "t3");
      cycle(1, 0, 16'h0, 1, N_IN, 255, "t3");
      cycle(1, 1, ALL15, 0, 0, 0, "t3");
      cycle(1, 0, 16'h0, 0, 0, 0, "t3");
      check("t3.sat_spike", 32'(spike), 1);
      check("t3.sat_pot", 32'(out), 0);

      // ref_len 0, threshold 1: fire on every step, never refractory
      do_reset();
      cycle(1, 0, 16'h0, 1, N_IN + 1, 0, "t4");
      cycle(1, 0, 16'h0, 1, N_IN, 1, "t4");
      cycle(1, 1, 16'h1111, 0, 0, 0, "t4");
      for (int k = 0; k < 4; k++) begin
         cycle(1, 1, 16'h1111, 0, 0, 0, "t4");
         check("t4.spike", 32'(spike), 1);
         check("t4.refr", 32'(refractory), 0);
      end

      // Same-edge threshold write: update uses old threshold
      do_reset();
      cycle(1, 1, ALL15, 0, 0, 0, "t5");
      cycle(1, 1, ALL15, 1, N_IN, 10, "t5");
      check("t5.old_thr", 32'(spike), 0);
      check("t5.pot60", 32'(out), 3);
      cycle(1, 0, 16'h0, 0, 0, 0, "t5");
      check("t5.new_thr", 32'(spike), 1);

      // Reset one cycle after a step discards it and restores config
      do_reset();
      cycle(1, 0, 16'h0, 1, N_IN, 10, "t6");
      cycle(1, 1, ALL15, 0, 0, 0, "t6");
      cycle(0, 0, 16'h0, 0, 0, 0, "t6");
      check("t6.rst_spike", 32'(spike), 0);
      check("t6.rst_pot", 32'(out), 0);
      cycle(1, 0, 16'h0, 0, 0, 0, "t6");
      check("t6.v1_clear", 32'(spike), 0);
      cycle(1, 1, ALL15, 0, 0, 0, "t6");
      cycle(1, 0, 16'h0, 0, 0, 0, "t6");
      check("t6.def_thr", 32'(spike), 0);
      check("t6.def_pot", 32'(out), 3);

      // Random traffic, including ignored addresses and occasional resets
      do_reset();
      for (int k = 0; k < 600; k++) begin
         cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 16'($urandom),
               ($urandom_range(0, 4) == 0), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 255)), "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
